// File: rtl/translate_hex_to_ascii_tx.sv
// translate_hex_to_ascii_tx
// Serialises a NUM_BYTES-wide binary word into ASCII hex characters,
// most-significant nibble first, over a valid/ready character interface.
// Optional trailer: define HEX_TX_CRLF_EN to append CR (0x0D) and LF (0x0A)
// after the last hex character of each word.
module translate_hex_to_ascii_tx #(
   parameter int unsigned NUM_BYTES = 2,
   parameter bit          UPPERCASE = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_BYTES*8-1:0] data_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [7:0]             char_out,
   output logic                   char_valid,
   input  logic                   char_ready,
   output logic                   busy
);

   localparam int unsigned W  = NUM_BYTES * 8;
   localparam int unsigned NN = NUM_BYTES * 2;
   localparam int unsigned CW = (NN > 1) ? $clog2(NN) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(NN - 1);

`ifdef HEX_TX_CRLF_EN
   typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;
`else
   typedef enum logic {IDLE, SEND} state_t;
`endif

   state_t         state_q, state_d;
   logic [W-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [7:0]     char_q,  char_d;
   logic           valid_q, valid_d;
   logic           fire;

   // Nibble to ASCII hex digit; 8-bit wrap-around arithmetic throughout
   function automatic logic [7:0] encode(input logic [3:0] n);
      logic [7:0] n8;
      n8 = {4'h0, n};
      if (n < 4'd10)
         return 8'h30 + n8;
      else if (UPPERCASE)
         return 8'h41 + n8 - 8'd10;
      else
         return 8'h61 + n8 - 8'd10;
   endfunction

   assign fire       = valid_q && char_ready;
   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign char_out   = char_q;
   assign char_valid = valid_q;

   // State, shift register, counter and registered character output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         char_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         char_q  <= char_d;
         valid_q <= valid_d;
      end
   end

   // Next-state and next-output logic; everything holds unless a handshake occurs
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      char_d  = char_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               shreg_d = data_in;
               cnt_d   = CNT_TOP;
               char_d  = encode(data_in[W-1 -: 4]);
               valid_d = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (fire) begin
               if (cnt_q != '0) begin
                  // The presented nibble sits at the top; the next one is just below it
                  shreg_d = shreg_q << 4;
                  cnt_d   = cnt_q - CW'(1);
                  char_d  = encode(shreg_q[W-5 -: 4]);
               end else begin
`ifdef HEX_TX_CRLF_EN
                  char_d  = 8'h0D;
                  state_d = CR;
`else
                  valid_d = 1'b0;
                  state_d = IDLE;
`endif
               end
            end
         end
`ifdef HEX_TX_CRLF_EN
         CR: begin
            if (fire) begin
               char_d  = 8'h0A;
               state_d = LF;
            end
         end
         LF: begin
            if (fire) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
`endif
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_translate_hex_to_ascii_tx.sv
// Testbench for translate_hex_to_ascii_tx (NUM_BYTES=2, UPPERCASE=1).
// Expected characters are queued when a word is driven; handshaked characters
// are collected and compared against that queue at the end of each scenario.
module tb_translate_hex_to_ascii_tx;

   localparam int NB = 2;
   localparam bit UC = 1'b1;
`ifdef HEX_TX_CRLF_EN
   localparam int NCH = NB * 2 + 2;
`else
   localparam int NCH = NB * 2;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NB*8-1:0] data_in;
   logic            in_valid;
   logic            in_ready;
   logic [7:0]      char_out;
   logic            char_valid;
   logic            char_ready;
   logic            busy;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   translate_hex_to_ascii_tx #(.NUM_BYTES(NB), .UPPERCASE(UC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .char_out   (char_out),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Collect every character that will be consumed at the coming rising edge
   always @(negedge clk) begin
      if (rst_n === 1'b1 && char_valid === 1'b1 && char_ready === 1'b1)
         got_q.push_back(char_out);
   end

   function automatic logic [7:0] model_char(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + 8'(n);
      return (UC ? 8'h41 : 8'h61) + 8'(n) - 8'd10;
   endfunction

   task automatic push_word(input logic [NB*8-1:0] w);
      for (int i = NB * 2 - 1; i >= 0; i--)
         exp_q.push_back(model_char(w[i*4 +: 4]));
`ifdef HEX_TX_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; data_in = '0; char_ready = 1'b1;
      step(); step();
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests++; if (char_valid !== 1'b0) begin fails++; $display("FAIL reset_char_valid got %b exp 0", char_valid); end
      tests++; if (char_out !== 8'h00) begin fails++; $display("FAIL reset_char_out got %h exp 00", char_out); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      step();
      rst_n = 1'b1;
      step();
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_basic();
      logic [7:0] seq [6] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
      logic [7:0] e, g;
      in_valid = 1'b1; data_in = 16'h1A2F; push_word(16'h1A2F);
      @(negedge clk);
      tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL basic_pre_accept in_ready %b busy %b exp 1 0", in_ready, busy); end
      step();
      in_valid = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         @(negedge clk);
         tests++; if (char_valid !== 1'b1 || busy !== 1'b1 || char_out !== seq[i])
            begin fails++; $display("FAIL basic_char%0d got v%b b%b %h exp v1 b1 %h", i, char_valid, busy, char_out, seq[i]); end
         step();
      end
      @(negedge clk);
      tests++; if (busy !== 1'b0 || in_ready !== 1'b1 || char_valid !== 1'b0)
         begin fails++; $display("FAIL basic_done busy %b in_ready %b valid %b exp 0 1 0", busy, in_ready, char_valid); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL basic_sb got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0] e, g;
      step();
      in_valid = 1'b1; data_in = 16'h0000; push_word(16'h0000);
      step();
      data_in = 16'hFFFF; push_word(16'hFFFF);
      for (int i = 0; i < NCH; i++) begin
         @(negedge clk);
         tests++; if (char_valid !== 1'b1 || in_ready !== 1'b0)
            begin fails++; $display("FAIL b2b_w0_c%0d valid %b in_ready %b exp 1 0", i, char_valid, in_ready); end
         step();
      end
      @(negedge clk);
      tests++; if (char_valid !== 1'b0 || in_ready !== 1'b1)
         begin fails++; $display("FAIL b2b_gap valid %b in_ready %b exp 0 1", char_valid, in_ready); end
      step();
      in_valid = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         @(negedge clk);
         tests++; if (char_valid !== 1'b1)
            begin fails++; $display("FAIL b2b_w1_c%0d valid %b exp 1", i, char_valid); end
         step();
      end
      @(negedge clk);
      tests++; if (char_valid !== 1'b0 || busy !== 1'b0)
         begin fails++; $display("FAIL b2b_done valid %b busy %b exp 0 0", char_valid, busy); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL b2b_sb got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_backpressure();
      logic [7:0] e, g;
      int k;
      step();
      in_valid = 1'b1; data_in = 16'hBEEF; push_word(16'hBEEF);
      step();
      in_valid = 1'b0;
      step();
      char_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++; if (char_valid !== 1'b1 || char_out !== 8'h45 || busy !== 1'b1)
            begin fails++; $display("FAIL bp_hold%0d valid %b char %h busy %b exp 1 45 1", i, char_valid, char_out, busy); end
         step();
      end
      char_ready = 1'b1;
      k = 0;
      while (busy === 1'b1 && k < 40) begin step(); k++; end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_timeout busy %b exp 0", busy); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL bp_sb got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] e, g;
      int k;
      step();
      in_valid = 1'b1; data_in = 16'h1234;
      exp_q.push_back(8'h31); exp_q.push_back(8'h32);
      step();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if (char_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || char_out !== 8'h00)
         begin fails++; $display("FAIL rst_mid valid %b busy %b in_ready %b char %h exp 0 0 1 00", char_valid, busy, in_ready, char_out); end
      step();
      in_valid = 1'b1; data_in = 16'h5678; push_word(16'h5678);
      step();
      in_valid = 1'b0;
      k = 0;
      while (busy === 1'b1 && k < 40) begin step(); k++; end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_timeout busy %b exp 0", busy); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_mid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL rst_mid_sb got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_ignore_in_valid();
      logic [7:0] e, g;
      step();
      in_valid = 1'b1; data_in = 16'hC0DE; push_word(16'hC0DE);
      step();
      in_valid = 1'b0;
      step();
      in_valid = 1'b1; data_in = 16'h9999;
      step();
      in_valid = 1'b0; data_in = '0;
      for (int i = 0; i < NCH + 4; i++) step();
      @(negedge clk);
      tests++; if (char_valid !== 1'b0 || busy !== 1'b0)
         begin fails++; $display("FAIL ign_idle valid %b busy %b exp 0 0", char_valid, busy); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL ign_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL ign_sb got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      test_ignore_in_valid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
